mmio_sonar: RTL

Memory-mapped ultrasonic ranger peripheral that responds to the processor's data-memory bus, alongside the data RAM. The processor starts a measurement with a store. The block drives the sensor trigger pulse and times the echo pulse in clock cycles. The processor reads status and result with loads, using the same one-cycle read latency as the data RAM. The top level muxes this block's read data over the RAM's read data whenever `hit_q` is high.

---
 rtl/sonar_pkg.sv | 33 +++
 rtl/mmio_sonar_sync_edge.sv | 33 +++
 rtl/mmio_sonar.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/sonar_pkg.sv
// Shared types and register-map constants for the memory-mapped ultrasonic ranger.
// No logic of its own; latency and flow control are defined by the users of this package.
// No backpressure: the processor bus is a fixed-timing store/load port.
package sonar_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_RISE = 3'd2,
        MEASURE   = 3'd3,
        DONE      = 3'd4
    } state_e;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_RESULT = 2'd2;

    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_TIMEOUT = 2;

    function automatic logic [31:0] status_word(input logic busy,
                                                input logic done,
                                                input logic timeout);
        logic [31:0] w;
        w              = '0;
        w[ST_BUSY]     = busy;
        w[ST_DONE]     = done;
        w[ST_TIMEOUT]  = timeout;
        return w;
    endfunction

endpackage

// File: rtl/mmio_sonar_sync_edge.sv
// Two-flop synchronizer for an asynchronous input plus rising/falling edge pulses.
// Latency: level visible 2 cycles after the pin changes; edge pulses last one cycle.
// No backpressure: free-running sampler.
module sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/mmio_sonar.sv
// Ultrasonic ranger on the data-memory bus: store to start, loads for status and echo width.
// Latency: read data and hit one cycle after the address; trig rises two edges after the start store.
// No backpressure: stores always accepted, a start while busy is dropped.
module mmio_sonar
    import sonar_pkg::*;
#(
    parameter logic [11:0] BASE_ADDR      = 12'hF00,
    parameter int          TRIG_CYCLES    = 500,
    parameter int          TIMEOUT_CYCLES = 1_900_000,
    parameter int          CNT_W          = 21
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wren,
    input  logic [11:0] address_dmem,
    input  logic [31:0] data,
    output logic [31:0] q_sonar,
    output logic        hit_q,
    output logic        trig,
    input  logic        echo,
    output logic        done_irq
);

    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LIMIT  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // ---------------- bus decode ----------------
    logic       in_win;
    logic [1:0] off;
    logic       start_req;
    logic       clr_done;
    logic       clr_timeout;
    logic       unused_data;

    assign in_win      = (address_dmem[11:2] == BASE_ADDR[11:2]);
    assign off         = address_dmem[1:0];
    assign start_req   = wren && in_win && (off == OFF_CTRL)   && data[0];
    assign clr_done    = wren && in_win && (off == OFF_STATUS) && data[ST_DONE];
    assign clr_timeout = wren && in_win && (off == OFF_STATUS) && data[ST_TIMEOUT];
    assign unused_data = ^data[31:3];

    // ---------------- echo synchronizer ----------------
    logic echo_s;
    logic echo_rise;
    logic echo_fall;

    sync_edge u_sync_echo (
        .clock  (clock),
        .reset  (reset),
        .d_i    (echo),
        .sync_o (echo_s),
        .rise_o (echo_rise),
        .fall_o (echo_fall)
    );

    // ---------------- measurement FSM ----------------
    state_e           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [CNT_W-1:0] result_q,  result_d;
    logic             done_q,    done_d;
    logic             timeout_q, timeout_d;
    logic             trig_q;
    logic             done_irq_q;
    logic             busy;

    assign busy = (state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        // Clears apply first so a completion in the same cycle overrides them.
        done_d    = done_q    & ~clr_done;
        timeout_d = timeout_q & ~clr_timeout;

        unique case (state_q)
            IDLE: begin
                if (start_req) begin
                    state_d   = TRIG;
                    cnt_d     = '0;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            TRIG: begin
                if (cnt_q == TRIG_LAST) begin
                    state_d = WAIT_RISE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            WAIT_RISE: begin
                if (echo_rise) begin
                    state_d = MEASURE;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LIMIT) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    result_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            MEASURE: begin
                if (echo_fall) begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    result_d = cnt_q;
                end else if (cnt_q == TO_LIMIT) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    result_d  = TO_LIMIT;
                end else if (echo_s) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            result_q   <= '0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            trig_q     <= 1'b0;
            done_irq_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            // Registered pin drive: high for exactly the cycles the FSM spends in TRIG.
            trig_q     <= (state_q == TRIG);
            done_irq_q <= (state_d == DONE) && (state_q != DONE);
        end
    end

    assign trig     = trig_q;
    assign done_irq = done_irq_q;

    // ---------------- read path ----------------
    logic [31:0] rdata_d;
    logic [31:0] rdata_q;
    logic        hit_r;

    always_comb begin
        rdata_d = '0;
        if (in_win) begin
            unique case (off)
                OFF_STATUS: rdata_d = status_word(busy, done_q, timeout_q);
                OFF_RESULT: rdata_d = 32'(result_q);
                default:    rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
            hit_r   <= 1'b0;
        end else begin
            rdata_q <= rdata_d;
            hit_r   <= in_win;
        end
    end

    assign q_sonar = rdata_q;
    assign hit_q   = hit_r;

endmodule
